// File: rtl/hack_pkg.sv
// Shared definitions for the Hack data-memory responder: memory map constants,
// scan-out FSM state encoding and the address decode helper.
package hack_pkg;

    localparam int          RAM_AW    = 14;
    localparam int          SCR_AW    = 13;
    localparam int          RAM_WORDS = 1 << RAM_AW;
    localparam int          SCR_WORDS = 1 << SCR_AW;
    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam logic [15:0] SCR_BASE  = 16'h4000;
    localparam logic [15:0] KBD_ADDR  = 16'h6000;

    // Index of the final screen word; the display uses it as end of frame.
    localparam logic [SCR_AW-1:0] SCR_LAST = SCR_AW'(SCR_WORDS - 1);

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_FETCH = 2'd1,
        SCAN_HOLD  = 2'd2
    } scan_state_t;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_SCR,
        REGION_KBD,
        REGION_NONE
    } region_t;

    // RAM is the bottom quarter, the screen the next eighth, the keyboard a
    // single word; everything else in the 16-bit space is unmapped.
    function automatic region_t decode_addr(input logic [15:0] addr);
        if (addr[15:14] == RAM_BASE[15:14]) begin
            return REGION_RAM;
        end else if (addr[15:13] == SCR_BASE[15:13]) begin
            return REGION_SCR;
        end else if (addr == KBD_ADDR) begin
            return REGION_KBD;
        end else begin
            return REGION_NONE;
        end
    endfunction

endpackage

// File: rtl/hack_ram_2r1w.sv
// Word-wide memory with one write port, one combinational read port and one
// registered read port with read enable. Contents are never reset; only the
// registered read data is cleared by reset.
module hack_ram_2r1w #(
    parameter int DEPTH = 16384,
    parameter int DW    = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] araddr,
    output logic [DW-1:0] ardata,
    input  logic          sre,
    input  logic [AW-1:0] sraddr,
    output logic [DW-1:0] srdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] srdata_d;
    logic [DW-1:0] srdata_q;

    // Storage array write; a read in the same cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered port only captures when enabled, otherwise it holds its word.
    always_comb begin
        srdata_d = srdata_q;
        if (sre) begin
            srdata_d = mem[sraddr];
        end
    end

    // Registered read data flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            srdata_q <= '0;
        end else begin
            srdata_q <= srdata_d;
        end
    end

    assign ardata = mem[araddr];
    assign srdata = srdata_q;

endmodule

// File: rtl/hack_mem_map.sv
// Data-port responder for the Hack core: RAM, screen buffer and keyboard
// register answered combinationally, plus a screen scan-out stream and a
// keyboard input handshake.
module hack_mem_map
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        xrst,
    input  logic [15:0] addr_m,
    input  logic [15:0] out_m,
    input  logic        write_m,
    output logic [15:0] in_m,
    output logic        addr_err,
    input  logic        scan_en,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic        pix_last,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_data,
    output logic        kbd_ready
);

    region_t             region;
    logic                ram_we;
    logic                scr_we;
    logic                kbd_clr;
    logic [15:0]         ram_rdata;
    logic [15:0]         scr_rdata;
    logic [15:0]         ram_sync_unused;
    logic                scan_fetch;

    scan_state_t         state_d, state_q;
    logic [SCR_AW-1:0]   scan_addr_d, scan_addr_q;
    logic                pix_last_d, pix_last_q;
    logic [15:0]         key_reg_d, key_reg_q;
    logic                key_full_d, key_full_q;
    logic                addr_err_d, addr_err_q;

    assign region  = decode_addr(addr_m);
    assign ram_we  = write_m && (region == REGION_RAM);
    assign scr_we  = write_m && (region == REGION_SCR);
    assign kbd_clr = write_m && (region == REGION_KBD);

    hack_ram_2r1w #(.DEPTH(RAM_WORDS), .DW(16)) u_ram (
        .clk    (clk),
        .rst    (xrst),
        .we     (ram_we),
        .waddr  (addr_m[RAM_AW-1:0]),
        .wdata  (out_m),
        .araddr (addr_m[RAM_AW-1:0]),
        .ardata (ram_rdata),
        .sre    (1'b0),
        .sraddr ('0),
        .srdata (ram_sync_unused)
    );

    hack_ram_2r1w #(.DEPTH(SCR_WORDS), .DW(16)) u_screen (
        .clk    (clk),
        .rst    (xrst),
        .we     (scr_we),
        .waddr  (addr_m[SCR_AW-1:0]),
        .wdata  (out_m),
        .araddr (addr_m[SCR_AW-1:0]),
        .ardata (scr_rdata),
        .sre    (scan_fetch),
        .sraddr (scan_addr_q),
        .srdata (pix_data)
    );

    // CPU read mux; unmapped addresses read as zero.
    always_comb begin
        in_m = 16'h0000;
        unique case (region)
            REGION_RAM:  in_m = ram_rdata;
            REGION_SCR:  in_m = scr_rdata;
            REGION_KBD:  in_m = key_reg_q;
            REGION_NONE: in_m = 16'h0000;
            default:     in_m = 16'h0000;
        endcase
    end

    // Keyboard register: a key load takes priority over a CPU clear, and a
    // full register ignores further offers until the CPU clears it.
    always_comb begin
        key_reg_d  = key_reg_q;
        key_full_d = key_full_q;
        if (kbd_valid && !key_full_q) begin
            key_reg_d  = kbd_data;
            key_full_d = 1'b1;
        end else if (kbd_clr) begin
            key_reg_d  = 16'h0000;
            key_full_d = 1'b0;
        end
    end

    // A write that hits no region raises a one-cycle error flag.
    always_comb begin
        addr_err_d = write_m && (region == REGION_NONE);
    end

    // Scan-out FSM: fetch a word into the registered port, then hold it until
    // the display takes it; the held word survives scan_en dropping.
    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        pix_last_d  = pix_last_q;
        scan_fetch  = 1'b0;
        pix_valid   = 1'b0;
        unique case (state_q)
            SCAN_IDLE: begin
                if (scan_en) begin
                    state_d = SCAN_FETCH;
                end
            end
            SCAN_FETCH: begin
                scan_fetch = 1'b1;
                pix_last_d = (scan_addr_q == SCR_LAST);
                state_d    = SCAN_HOLD;
            end
            SCAN_HOLD: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    scan_addr_d = scan_addr_q + 1'b1;
                    state_d     = scan_en ? SCAN_FETCH : SCAN_IDLE;
                end
            end
            default: begin
                state_d = SCAN_IDLE;
            end
        endcase
    end

    // State registers for the scan FSM, keyboard and error flag.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q     <= SCAN_IDLE;
            scan_addr_q <= '0;
            pix_last_q  <= 1'b0;
            key_reg_q   <= 16'h0000;
            key_full_q  <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            pix_last_q  <= pix_last_d;
            key_reg_q   <= key_reg_d;
            key_full_q  <= key_full_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign pix_last  = pix_last_q;
    assign kbd_ready = !key_full_q;
    assign addr_err  = addr_err_q;

endmodule
